mr_if: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decode stage and drives its inst/inst_pc/inst_valid/inst_ready handshake.
- Holds the PC and issues word reads on a split request/response instruction-memory port, with up to FIFO_DEPTH requests outstanding.
- Buffers returned words in an in-order FIFO.
- On a taken-branch redirect from execute, flushes the FIFO, discards in-flight responses and refetches from the target.

---
 rtl/mr_if_pkg.sv | 8 +
 rtl/mr_if_fifo.sv | 75 +++++++
 rtl/mr_if.sv | 167 ++++++++++++++++
 tb/tb_mr_if.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr_if_pkg.sv
// Shared widths and constants for the mr_if instruction fetch stage.
package mr_if_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned IMAXLEN       = 32;
  localparam int unsigned IF_INST_BYTES = 4;

endpackage

// File: rtl/mr_if_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
// The head is read straight from storage, so rdata shows a write one cycle
// after the push edge (no bypass).
module mr_if_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointer/count update; flush wins over push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mr_if.sv
// Instruction fetch stage: credit-limited requests on a split req/rsp
// instruction-memory port, in-order instruction buffer towards decode, and
// redirect handling that flushes buffered words and drops in-flight responses.
// Optional build macro MR_IF_PERF_EN adds perf_fetched/perf_dropped/perf_stall.
module mr_if
  import mr_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [IMAXLEN-1:0] imem_rdata,
  output logic [IMAXLEN-1:0] inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  input  logic               redir_valid,
`ifdef MR_IF_PERF_EN
  input  logic [XLEN-1:0]    redir_pc,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped,
  output logic [31:0]        perf_stall
`else
  input  logic [XLEN-1:0]    redir_pc
`endif
);

  // FIFO occupancy width; outstanding/drop get headroom because repeated
  // redirects against a slow memory can leave several dropped responses in flight.
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 3;
  localparam int unsigned BW = IMAXLEN + XLEN;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            run_q, run_d;

  logic [CW-1:0]   ibuf_count, tagq_count;
  logic [BW-1:0]   ibuf_head;
  logic [XLEN-1:0] tag_head;
  logic            ibuf_empty, ibuf_full, tagq_empty, tagq_full;
  logic [OW:0]     credit;
  logic            grant, rsp_drop, rsp_keep, ibuf_pop;

  // Request credit and response classification from registered state.
  always_comb begin
    credit    = (OW+1)'(ibuf_count) + (OW+1)'(out_q) - (OW+1)'(drop_q);
    imem_req  = run_q && !redir_valid && (credit < (OW+1)'(FIFO_DEPTH));
    imem_addr = pc_q;
    grant     = imem_req && imem_gnt;
    rsp_drop  = imem_rvalid && (drop_q != '0);
    rsp_keep  = imem_rvalid && (drop_q == '0) && !redir_valid;
    ibuf_pop  = inst_valid && inst_ready && !redir_valid;
  end

  // Next PC, outstanding and drop counters.
  always_comb begin
    run_d = 1'b1;
    pc_d  = pc_q;
    out_d = out_q + OW'(grant) - OW'(imem_rvalid);
    if (redir_valid) begin
      pc_d   = {redir_pc[XLEN-1:2], 2'b00};
      drop_d = out_q - OW'(imem_rvalid);
    end else begin
      if (grant) pc_d = pc_q + XLEN'(IF_INST_BYTES);
      drop_d = drop_q - OW'(rsp_drop);
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      run_q  <= run_d;
    end
  end

  mr_if_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tagq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (grant),
    .wdata (pc_q),
    .pop   (rsp_keep),
    .flush (redir_valid),
    .rdata (tag_head),
    .count (tagq_count),
    .empty (tagq_empty),
    .full  (tagq_full)
  );

  mr_if_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .wdata ({imem_rdata, tag_head}),
    .pop   (ibuf_pop),
    .flush (redir_valid),
    .rdata (ibuf_head),
    .count (ibuf_count),
    .empty (ibuf_empty),
    .full  (ibuf_full)
  );

  assign inst_valid = !ibuf_empty;
  assign inst       = ibuf_head[BW-1:XLEN];
  assign inst_pc    = ibuf_head[XLEN-1:0];

`ifdef MR_IF_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Performance counter increments; a response landing on a redirect is discarded too.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(rsp_keep);
    perf_dropped_d = perf_dropped_q + 32'(rsp_drop || (imem_rvalid && redir_valid))
                   + 32'(redir_valid ? ibuf_count : CW'(0));
    perf_stall_d   = perf_stall_q + 32'(inst_ready && !inst_valid);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_no_stray_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (out_q == '0)));
  a_ibuf_no_ovf  : assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && ibuf_full && !ibuf_pop));
  a_tag_present  : assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && tagq_empty));
  a_tagq_no_ovf  : assert property (@(posedge clk) disable iff (!rst_n)
    !(grant && tagq_full));
  a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
    ((CW+1)'(tagq_count) + (CW+1)'(ibuf_count)) <= (CW+1)'(FIFO_DEPTH));
  a_out_headroom : assert property (@(posedge clk) disable iff (!rst_n)
    !(grant && (out_q == '1)));
`endif

endmodule

// File: tb/tb_mr_if.sv
// Scoreboard bench for mr_if: an in-order memory model answers grants, the
// expected {pc, word} stream is queued at each grant and compared at each pop.
module tb_mr_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redir_valid;
  logic [31:0] redir_pc;
`ifdef MR_IF_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  always #5 clk = ~clk;

  mr_if #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redir_valid (redir_valid),
`ifdef MR_IF_PERF_EN
    .redir_pc    (redir_pc),
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped),
    .perf_stall  (perf_stall)
`else
    .redir_pc    (redir_pc)
`endif
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_n, lat_min, lat_max;
  logic [31:0] exp_pc;
  int          n_grants, n_pops, first_grant_cyc, first_valid_cyc;
  logic        first_pop_seen, vld_seen;
  logic [31:0] first_pop_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive at negedge, observe, update the model for the next edge.
  task automatic cyc(input logic rdy, input logic gnt, input logic rv, input logic [31:0] rpc);
    exp_t        e;
    pend_t       p;
    logic [31:0] due;
    @(negedge clk);
    inst_ready  = rdy;
    imem_gnt    = gnt;
    redir_valid = rv;
    redir_pc    = rpc;
    if (pend.size() > 0 && pend[0].due <= 32'(cyc_n)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    vld_seen = inst_valid;
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (rv) check("req_in_redir", 64'(imem_req), 64'(0));
    if (inst_valid && inst_ready && !rv) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("inst_pc", 64'(inst_pc), 64'(e.pc));
        check("inst", 64'(inst), 64'(e.word));
        if (!first_pop_seen) begin
          first_pop_seen = 1'b1;
          first_pop_pc   = inst_pc;
        end
      end
      n_pops++;
    end
    if (imem_req && imem_gnt) begin
      check("imem_addr", 64'(imem_addr), 64'(exp_pc));
      e.pc   = imem_addr;
      e.word = mem_word(imem_addr);
      sb.push_back(e);
      due = 32'(cyc_n + $urandom_range(lat_max, lat_min));
      if (pend.size() > 0 && pend[pend.size()-1].due > due) due = pend[pend.size()-1].due;
      p.addr = imem_addr;
      p.due  = due;
      pend.push_back(p);
      if (first_grant_cyc < 0) first_grant_cyc = cyc_n;
      exp_pc = exp_pc + 32'd4;
      n_grants++;
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (rv) begin
      sb.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end
    cyc_n++;
  endtask

  task automatic do_reset(input int lmin, input int lmax);
    rst_n       = 1'b0;
    inst_ready  = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_valid", 64'(inst_valid), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_inst", 64'(inst), 64'(0));
    check("rst_inst_pc", 64'(inst_pc), 64'(0));
    sb.delete();
    pend.delete();
    exp_pc          = 32'h0;
    cyc_n           = 0;
    n_grants        = 0;
    n_pops          = 0;
    first_grant_cyc = -1;
    first_valid_cyc = -1;
    first_pop_seen  = 1'b0;
    first_pop_pc    = '0;
    lat_min         = lmin;
    lat_max         = lmax;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    check({tag, "_pend_empty"}, 64'(pend.size()), 64'(0));
  endtask

  initial begin
    logic [31:0] addr0;
    logic        found;

    // 1: streaming with 1-cycle memory
    do_reset(1, 1);
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s1_valid_latency", 64'(first_valid_cyc - first_grant_cyc), 64'(2));
    check("s1_pops", 64'(n_pops >= 6), 64'(1));
    drain("s1");

    // 2: decode stalled, credit stops fetch at FIFO_DEPTH
    do_reset(1, 1);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("s2_grants", 64'(n_grants), 64'(2));
    check("s2_req_off", 64'(imem_req), 64'(0));
    check("s2_valid", 64'(inst_valid), 64'(1));
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s2_resumed", 64'(n_grants > 2), 64'(1));
    check("s2_pops", 64'(n_pops >= 2), 64'(1));
    drain("s2");

    // 3: redirect with two slow responses in flight
    do_reset(3, 3);
    for (int i = 0; i < 10 && n_grants < 2; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s3_grants", 64'(n_grants), 64'(2));
    n_pops         = 0;
    first_pop_seen = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 32'h100);
    repeat (20) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s3_first_pop_seen", 64'(first_pop_seen), 64'(1));
    check("s3_first_pc", 64'(first_pop_pc), 64'h100);
    drain("s3");
`ifdef MR_IF_PERF_EN
    check("s3_perf_dropped", 64'(perf_dropped), 64'(2));
    check("s3_perf_fetched", 64'(perf_fetched), 64'(n_pops));
`endif

    // 4: redirect coinciding with a response and a pop
    do_reset(2, 2);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (inst_valid && pend.size() > 0 && pend[0].due <= 32'(cyc_n)) begin
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        found = 1'b1;
      end else begin
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
      end
    end
    check("s4_found", 64'(found), 64'(1));
    first_pop_seen = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s4_valid_after_redir", 64'(vld_seen), 64'(0));
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s4_first_pc", 64'(first_pop_pc), 64'h200);
    drain("s4");

    // 5: grant withheld for 5 cycles
    do_reset(1, 1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    addr0 = imem_addr;
    check("s5_addr0", 64'(addr0), 64'h0);
    check("s5_req0", 64'(imem_req), 64'(1));
    repeat (4) begin
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      check("s5_addr_stable", 64'(imem_addr), 64'(addr0));
      check("s5_req_held", 64'(imem_req), 64'(1));
      check("s5_no_valid", 64'(inst_valid), 64'(0));
    end
`ifdef MR_IF_PERF_EN
    @(posedge clk);
    #1;
    check("s5_perf_stall", 64'(perf_stall), 64'(5));
`endif
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s5_granted", 64'(n_grants > 0), 64'(1));
    drain("s5");

    // 6: unaligned redirect near the top of the address space, PC wraps
    do_reset(1, 1);
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFA);
    repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("s6_first_pc", 64'(first_pop_pc), 64'hFFFF_FFF8);
    check("s6_wrapped", 64'(n_pops >= 4), 64'(1));
    drain("s6");

    // 7: random ready/grant/latency with occasional redirects
    do_reset(1, 4);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19, 0) == 0)
        cyc(1'($urandom_range(1, 0)), 1'b1, 1'b1, $urandom & 32'h0000_FFFF);
      else
        cyc(1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0), 1'b0, 32'h0);
    end
    check("s7_progress", 64'(n_pops > 20), 64'(1));
    drain("s7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
